// File: rtl/pipelined_right_shifter_if.sv
// Streaming bus for pipelined_right_shifter: operand side plus result side.
// PIPELINED_RIGHT_SHIFTER_ROTATE_EN adds the per-operation Rotate bit.
interface pipelined_right_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHIFT_BITS = $clog2(WIDTH);

    // Valid/ready: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload until then, and ready never depends on valid.
    logic [WIDTH-1:0]      In;
    logic [SHIFT_BITS-1:0] ShiftAmount;
    logic                  ShiftIn;
    logic                  InValid;
    logic                  InReady;
    logic [WIDTH-1:0]      Out;
    logic                  OutValid;
    logic                  OutReady;
    logic                  Busy;
`ifdef PIPELINED_RIGHT_SHIFTER_ROTATE_EN
    logic                  Rotate;

    modport master (
        output In, ShiftAmount, ShiftIn, Rotate, InValid, OutReady,
        input  InReady, Out, OutValid, Busy
    );
    modport slave (
        input  In, ShiftAmount, ShiftIn, Rotate, InValid, OutReady,
        output InReady, Out, OutValid, Busy
    );
`else
    modport master (
        output In, ShiftAmount, ShiftIn, InValid, OutReady,
        input  InReady, Out, OutValid, Busy
    );
    modport slave (
        input  In, ShiftAmount, ShiftIn, InValid, OutReady,
        output InReady, Out, OutValid, Busy
    );
`endif
endinterface

// File: rtl/pipelined_right_shifter.sv
// Pipelined right barrel shifter, one register per mux level (largest shift first).
// Optional rotate mode via PIPELINED_RIGHT_SHIFTER_ROTATE_EN.
module pipelined_right_shifter #(
    parameter int WIDTH = 32
) (
    input logic                      Clock,
    input logic                      Reset,
    pipelined_right_shifter_if.slave bus
);
    localparam int SHIFT_BITS = $clog2(WIDTH);

    typedef logic [WIDTH-1:0]      data_t;
    typedef logic [SHIFT_BITS-1:0] amt_t;

    data_t               data_q   [1:SHIFT_BITS];
    amt_t                amt_q    [1:SHIFT_BITS];
    logic                fill_q   [1:SHIFT_BITS];
    logic                rot_q    [1:SHIFT_BITS];
    logic [SHIFT_BITS:1] valid_q;

    data_t               data_d   [1:SHIFT_BITS];
    data_t               src_data [1:SHIFT_BITS];
    amt_t                src_amt  [1:SHIFT_BITS];
    logic                src_fill [1:SHIFT_BITS];
    logic                src_rot  [1:SHIFT_BITS];
    logic [SHIFT_BITS:1] src_valid;
    logic [SHIFT_BITS:1] load;
    logic                rot_in;

`ifdef PIPELINED_RIGHT_SHIFTER_ROTATE_EN
    assign rot_in = bus.Rotate;
`else
    assign rot_in = 1'b0;
`endif

    function automatic data_t shift_right(input data_t v, input int s,
                                          input logic fill, input logic rot);
        data_t ones;
        ones = '1;
        if (rot)
            return (v >> s) | (v << (WIDTH - s));
        return (v >> s) | (fill ? ~(ones >> s) : '0);
    endfunction

    // Stage k's input is stage k-1's register; stage 1 takes the bus.
    always_comb begin
        src_data[1]  = bus.In;
        src_amt[1]   = bus.ShiftAmount;
        src_fill[1]  = bus.ShiftIn;
        src_rot[1]   = rot_in;
        src_valid[1] = bus.InValid;
        for (int k = 2; k <= SHIFT_BITS; k++) begin
            src_data[k]  = data_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_fill[k]  = fill_q[k-1];
            src_rot[k]   = rot_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
        for (int k = 1; k <= SHIFT_BITS; k++) begin
            data_d[k] = src_amt[k][SHIFT_BITS-k]
                      ? shift_right(src_data[k], 1 << (SHIFT_BITS - k), src_fill[k], src_rot[k])
                      : src_data[k];
        end
    end

    // A stage loads when empty or when the stage after it is taking its entry.
    always_comb begin
        logic adv;
        adv  = valid_q[SHIFT_BITS] && bus.OutReady;
        load = '0;
        for (int k = SHIFT_BITS; k >= 1; k--) begin
            adv     = !valid_q[k] || adv;
            load[k] = adv;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= '0;
            for (int k = 1; k <= SHIFT_BITS; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                fill_q[k] <= 1'b0;
                rot_q[k]  <= 1'b0;
            end
        end else begin
            for (int k = 1; k <= SHIFT_BITS; k++) begin
                if (load[k]) begin
                    data_q[k]  <= data_d[k];
                    amt_q[k]   <= src_amt[k];
                    fill_q[k]  <= src_fill[k];
                    rot_q[k]   <= src_rot[k];
                    valid_q[k] <= src_valid[k];
                end
            end
        end
    end

    assign bus.InReady  = load[1];
    assign bus.Out      = data_q[SHIFT_BITS];
    assign bus.OutValid = valid_q[SHIFT_BITS];
    assign bus.Busy     = |valid_q;
endmodule

// File: tb/tb_pipelined_right_shifter.sv
// Self-checking bench for pipelined_right_shifter: directed cases plus random
// traffic against a queue-based reference of the shift/rotate function.
module tb_pipelined_right_shifter;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] exp_q[$];

  pipelined_right_shifter_if #(.WIDTH(W)) bus ();

  pipelined_right_shifter #(.WIDTH(W)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_fn(input logic [W-1:0] d, input int sa,
                                          input logic si, input logic rot);
    logic [2*W-1:0] dd;
    logic [W-1:0]   ones;
    ones = '1;
    dd = {d, d} >> sa;
    if (rot) return dd[W-1:0];
    return (d >> sa) | (si ? ~(ones >> sa) : '0);
  endfunction

  // One clock: drive at negedge, settle, then score both handshakes.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic [4:0] sa,
                       input logic si, input logic rot, input logic ordy,
                       input logic r, output logic acc);
    @(negedge clk);
    rst             = r;
    bus.InValid     = iv;
    bus.In          = d;
    bus.ShiftAmount = sa;
    bus.ShiftIn     = si;
`ifdef PIPELINED_RIGHT_SHIFTER_ROTATE_EN
    bus.Rotate      = rot;
`endif
    bus.OutReady    = ordy;
    #1;
    acc = iv && bus.InReady && !r;
    if (r) begin
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back(ref_fn(d, int'(sa), si, rot));
      if (bus.OutValid && bus.OutReady) begin
        if (exp_q.size() == 0) check("spurious_out", {31'd0, bus.OutValid}, '0);
        else check("out_data", bus.Out, exp_q.pop_front());
      end
    end
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 64 && (exp_q.size() != 0 || bus.Busy); i++)
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, a);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic acc;
    int   lat;
    int   n_acc;
    logic seen;
    logic rot_r;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.InValid = 1'b0;
    bus.In = '0;
    bus.ShiftAmount = '0;
    bus.ShiftIn = 1'b0;
    bus.OutReady = 1'b0;
`ifdef PIPELINED_RIGHT_SHIFTER_ROTATE_EN
    bus.Rotate = 1'b0;
`endif

    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    check("rst_out", bus.Out, '0);
    check("rst_outvalid", {31'd0, bus.OutValid}, '0);
    check("rst_busy", {31'd0, bus.Busy}, '0);
    check("rst_inready", {31'd0, bus.InReady}, 32'd1);

    // Basic shift and latency
    cycle(1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("basic_accept", {31'd0, acc}, 32'd1);
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      if (bus.OutValid) begin
        seen = 1'b1;
        lat = i;
      end
    end
    check("basic_latency", lat, 5);
    drain();

    // Fill and identity
    cycle(1'b1, 32'h1234_5678, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h8765_4321, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, acc);
    drain();

    // Backpressure: fill the pipe with OutReady low
    n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 5; i++) begin
      cycle(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'b0, 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("bp_accepts", n_acc, 5);
    cycle(1'b1, $urandom, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    if (acc) n_acc++;
    check("bp_full_inready", {31'd0, bus.InReady}, '0);
    check("bp_busy", {31'd0, bus.Busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(n_acc < 8, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'b0, 1'b1, 1'b0, acc);
      if (i == 0) check("bp_inready_rise", {31'd0, bus.InReady}, 32'd1);
      check("bp_stream_valid", {31'd0, bus.OutValid}, 32'd1);
      if (acc) n_acc++;
    end
    check("bp_total", n_acc, 8);
    drain();

    // Reset mid-flight, with a simultaneous accept attempt
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 3; i++) begin
      cycle(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    cycle(1'b1, 32'hA5A5_A5A5, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("mid_rst_outvalid", {31'd0, bus.OutValid}, '0);
    check("mid_rst_busy", {31'd0, bus.Busy}, '0);
    check("mid_rst_inready", {31'd0, bus.InReady}, 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h0F0F_0000, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("post_rst_accept", {31'd0, acc}, 32'd1);
    drain();

`ifdef PIPELINED_RIGHT_SHIFTER_ROTATE_EN
    cycle(1'b1, 32'h0000_00F1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h0000_00F1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    drain();
`endif

    // Random traffic with gaps on both sides
    n_acc = 0;
    for (int i = 0; i < 20000 && n_acc < 1000; i++) begin
`ifdef PIPELINED_RIGHT_SHIFTER_ROTATE_EN
      rot_r = 1'($urandom_range(0, 1));
`else
      rot_r = 1'b0;
`endif
      cycle($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), rot_r, $urandom_range(0, 3) != 0, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("rand_accepts", n_acc, 1000);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
